dmem_responder: RTL

Memory-side responder for the MEM-stage data-memory requests issued by the 5-stage pipeline. It accepts one load/store request at a time over a valid/ready handshake. It models a configurable number of wait states, performs byte-enabled writes and full-word reads, and returns a one-cycle response. While a request is outstanding it drives mem_stall so the pipeline freezes its MEM stage.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and address-decode helper for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // A request is rejected when it is not word aligned or addresses past the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int addr_w);
        logic misaligned_s;
        logic out_of_range_s;
        misaligned_s   = (addr[1:0] != 2'b00);
        out_of_range_s = ((addr >> (addr_w + 2)) != 32'd0);
        return misaligned_s | out_of_range_s;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              mem_stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_stall
    );

endinterface

// File: rtl/dmem_array.sv
// Word array with synchronous clear, one byte-enabled write port and a
// combinational read port sharing the same word index.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Storage: clear everything on reset, otherwise update only enabled bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WORD_W{1'b0}};
            end
        end else if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one outstanding request, programmable wait
// states, byte-enabled stores, one-cycle response strobe and pipeline stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    state_e            state_r;
    state_e            state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_s;
    logic              access_s;
    logic              use_bus_s;

    logic              we_r;
    logic [WORD_W-1:0] addr_r;
    logic [WORD_W-1:0] wdata_r;
    logic [BE_W-1:0]   be_r;

    logic              acc_we_s;
    logic [WORD_W-1:0] acc_addr_s;
    logic [WORD_W-1:0] acc_wdata_s;
    logic [BE_W-1:0]   acc_be_s;
    logic              acc_err_s;
    logic              wr_en_s;
    logic [WORD_W-1:0] arr_rdata_s;

    logic              resp_valid_r;
    logic [WORD_W-1:0] resp_rdata_r;
    logic              resp_err_r;

    // Next-state, wait counter and access strobe.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        access_s  = 1'b0;
        use_bus_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        // Zero wait states: the access happens on the acceptance edge.
                        access_s  = 1'b1;
                        use_bus_s = 1'b1;
                        state_s   = RESP;
                    end else begin
                        state_s = BUSY;
                        cnt_s   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    access_s = 1'b1;
                    state_s  = RESP;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Select the live request or the latched one as the source of the access.
    always_comb begin
        if (use_bus_s) begin
            acc_we_s    = bus.req_we;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
            acc_be_s    = bus.req_be;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

    assign acc_err_s = addr_err(acc_addr_s, ADDR_W);
    assign wr_en_s   = access_s & acc_we_s & ~acc_err_s;

    // FSM state and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_r    <= 1'b0;
            addr_r  <= {WORD_W{1'b0}};
            wdata_r <= {WORD_W{1'b0}};
            be_r    <= {BE_W{1'b0}};
        end else if ((state_r == IDLE) && bus.req_valid) begin
            we_r    <= bus.req_we;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            be_r    <= bus.req_be;
        end else begin
            we_r    <= we_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    // Response registers: loaded on the access edge, so the strobe lines up with RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {WORD_W{1'b0}};
            resp_err_r   <= 1'b0;
        end else if (access_s) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= (acc_we_s || acc_err_s) ? {WORD_W{1'b0}} : arr_rdata_s;
            resp_err_r   <= acc_err_s;
        end else begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= resp_rdata_r;
            resp_err_r   <= resp_err_r;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (wr_en_s),
        .idx   (acc_addr_s[ADDR_W+1:2]),
        .wdata (acc_wdata_s),
        .be    (acc_be_s),
        .rdata (arr_rdata_s)
    );

    assign bus.req_ready  = (state_r == IDLE);
    assign bus.mem_stall  = ((state_r == IDLE) && bus.req_valid) || (state_r == BUSY);
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;

endmodule
